// File: rtl/tl_test_indicator_pkg.sv
// Shared definitions for the multi-channel TileLink-UL test indicator:
// opcode constants, indicator register fields and the response-entry layout.
package tl_test_indicator_pkg;

    // TileLink-UL A-channel opcodes
    localparam logic [2:0] A_PUT_FULL    = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] A_GET         = 3'd4;

    // TileLink-UL D-channel opcodes
    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

    // Indicator register layout: {code[31:1], done[0]}
    localparam int DONE_BIT = 0;
    localparam int CODE_LSB = 1;

    // Response entries carry size/source at a fixed maximum width so one
    // struct serves every parameterisation (SIZE_W, SRC_W <= 8).
    localparam int RSP_SIZE_W = 8;
    localparam int RSP_SRC_W  = 8;

    typedef struct packed {
        logic [2:0]            opcode;
        logic [RSP_SIZE_W-1:0] size;
        logic [RSP_SRC_W-1:0]  source;
        logic                  denied;
        logic [31:0]           data;
    } rsp_t;

endpackage

// File: rtl/tl_ind_rsp_fifo.sv
// Synchronous DEPTH-entry FIFO of D-channel response entries. The head entry
// is presented directly so it stays stable until it is popped.
module tl_ind_rsp_fifo
    import tl_test_indicator_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  rsp_t wdata,
    output rsp_t head,
    output logic full,
    output logic empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    rsp_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // Pointer advance with explicit wrap so any DEPTH works
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Entry storage: payload only, never reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // Pointers and occupancy; simultaneous push and pop keep the count
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/tl_test_indicator_mc.sv
// Multi-channel TileLink-UL test-indicator slave. One 32-bit {code, done}
// register per channel, buffered in-order responses, a sticky A-channel
// protocol checker and a sticky watchdog.
module tl_test_indicator_mc
    import tl_test_indicator_pkg::*;
#(
    parameter int ADDR_W    = 15,
    parameter int SRC_W     = 2,
    parameter int SIZE_W    = 3,
    parameter int CHANNELS  = 4,
    parameter int RSP_DEPTH = 2,
    parameter int TIMEOUT   = 1000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [2:0]          a_param,
    input  logic [SIZE_W-1:0]   a_size,
    input  logic [SRC_W-1:0]    a_source,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic [3:0]          a_mask,
    input  logic [31:0]         a_data,
    output logic                d_valid,
    input  logic                d_ready,
    output logic [2:0]          d_opcode,
    output logic [SIZE_W-1:0]   d_size,
    output logic [SRC_W-1:0]    d_source,
    output logic                d_denied,
    output logic [31:0]         d_data,
    output logic [CHANNELS-1:0] finished,
    output logic [CHANNELS-1:0] failed,
    output logic                all_done,
    output logic                timeout,
    output logic                proto_err
);
    localparam int IDX_W  = ADDR_W - 2;
    localparam int HOLD_W = 3 + 3 + SIZE_W + SRC_W + ADDR_W + 4 + 32;
    localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [31:0]       ind_q [CHANNELS];
    logic              fire;
    logic [IDX_W-1:0]  word_idx;
    logic              in_range;
    logic              is_get;
    logic              is_put;
    logic              supported;
    logic              denied;
    logic              aligned;
    logic              wr_en;
    logic [ADDR_W-1:0] align_mask;
    logic [31:0]       rd_data;
    rsp_t              rsp_in;
    rsp_t              rsp_head;
    logic              q_full;
    logic              q_empty;
    logic              q_pop;
    logic              stall_q;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] a_bus;
    logic [WD_W-1:0]   wd_cnt;
    logic              timeout_q;
    logic              proto_q;
    logic              unused_rsp;

    // Acceptance depends only on the registered queue occupancy
    assign a_ready = !q_full;
    assign fire    = a_valid & a_ready;

    // The whole local address is decoded: anything past the last channel is denied
    assign word_idx   = a_address[ADDR_W-1:2];
    assign in_range   = (word_idx < IDX_W'(CHANNELS));
    assign is_get     = (a_opcode == A_GET);
    assign is_put     = (a_opcode == A_PUT_FULL) || (a_opcode == A_PUT_PARTIAL);
    assign supported  = is_get | is_put;
    assign denied     = !in_range || (a_size > SIZE_W'(2)) || !supported;
    assign align_mask = ADDR_W'((64'd1 << a_size) - 64'd1);
    assign aligned    = ((a_address & align_mask) == '0);
    assign wr_en      = fire & is_put & !denied;
    assign a_bus      = {a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data};

    // Read mux: register contents before any same-cycle write
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (word_idx == IDX_W'(i)) rd_data = ind_q[i];
        end
    end

    // Response entry built at the fire cycle
    always_comb begin
        rsp_in        = '0;
        rsp_in.opcode = is_get ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
        rsp_in.size   = RSP_SIZE_W'(a_size);
        rsp_in.source = RSP_SRC_W'(a_source);
        rsp_in.denied = denied;
        rsp_in.data   = (is_get && !denied) ? rd_data : '0;
    end

    // Indicator registers: byte-lane writes, locked once done is set
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) ind_q[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (word_idx == IDX_W'(i) && !ind_q[i][DONE_BIT]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (a_mask[b]) ind_q[i][8*b +: 8] <= a_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // Snapshot of the A-channel fields for the stall-stability check
    always_ff @(posedge clock) begin
        hold_q <= a_bus;
    end

    // Sticky protocol checker: unstable stalled requests, nonzero param,
    // misaligned address or unsupported opcode on fire
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= 1'b0;
            proto_q <= 1'b0;
        end else begin
            stall_q <= a_valid & !a_ready;
            if ((stall_q && (!a_valid || (a_bus != hold_q))) ||
                (fire && (!supported || (a_param != 3'd0) || !aligned))) begin
                proto_q <= 1'b1;
            end
        end
    end

    // Watchdog: counts while work is outstanding, frozen by all_done
    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else if ((TIMEOUT != 0) && !all_done && !timeout_q) begin
            if (wd_cnt == WD_W'(TIMEOUT - 1)) timeout_q <= 1'b1;
            else                              wd_cnt    <= wd_cnt + WD_W'(1);
        end
    end

    // Per-channel status from the register fields
    always_comb begin
        finished = '0;
        failed   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            finished[i] = ind_q[i][DONE_BIT];
            failed[i]   = ind_q[i][DONE_BIT] & (|ind_q[i][31:CODE_LSB]);
        end
    end

    assign all_done  = &finished;
    assign timeout   = timeout_q;
    assign proto_err = proto_q;

    tl_ind_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clock),
        .rst   (reset),
        .push  (fire),
        .pop   (q_pop),
        .wdata (rsp_in),
        .head  (rsp_head),
        .full  (q_full),
        .empty (q_empty)
    );

    // D channel: head entry, forced to zero while idle
    assign d_valid    = !q_empty;
    assign q_pop      = d_valid & d_ready;
    assign d_opcode   = d_valid ? rsp_head.opcode : '0;
    assign d_size     = d_valid ? SIZE_W'(rsp_head.size) : '0;
    assign d_source   = d_valid ? SRC_W'(rsp_head.source) : '0;
    assign d_denied   = d_valid & rsp_head.denied;
    assign d_data     = d_valid ? rsp_head.data : '0;
    assign unused_rsp = ^{rsp_head.size, rsp_head.source};

endmodule

// File: tb/tb_tl_test_indicator_mc.sv
// Bench for tl_test_indicator_mc: directed test-plan steps plus randomized
// traffic, checked against a transaction-level reference model.
module tb_tl_test_indicator_mc;
    localparam int ADDR_W    = 15;
    localparam int SRC_W     = 2;
    localparam int SIZE_W    = 3;
    localparam int CHANNELS  = 4;
    localparam int RSP_DEPTH = 2;
    localparam int TIMEOUT   = 20;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                a_valid = 1'b0;
    logic                a_ready;
    logic [2:0]          a_opcode = '0;
    logic [2:0]          a_param = '0;
    logic [SIZE_W-1:0]   a_size = '0;
    logic [SRC_W-1:0]    a_source = '0;
    logic [ADDR_W-1:0]   a_address = '0;
    logic [3:0]          a_mask = '0;
    logic [31:0]         a_data = '0;
    logic                d_valid;
    logic                d_ready = 1'b1;
    logic [2:0]          d_opcode;
    logic [SIZE_W-1:0]   d_size;
    logic [SRC_W-1:0]    d_source;
    logic                d_denied;
    logic [31:0]         d_data;
    logic [CHANNELS-1:0] finished;
    logic [CHANNELS-1:0] failed;
    logic                all_done;
    logic                timeout;
    logic                proto_err;

    always #5 clock = ~clock;

    tl_test_indicator_mc #(
        .ADDR_W(ADDR_W), .SRC_W(SRC_W), .SIZE_W(SIZE_W),
        .CHANNELS(CHANNELS), .RSP_DEPTH(RSP_DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
        .d_source(d_source), .d_denied(d_denied), .d_data(d_data),
        .finished(finished), .failed(failed), .all_done(all_done),
        .timeout(timeout), .proto_err(proto_err)
    );

    int total = 0;
    int bad   = 0;
    bit rnd_on = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0]  op;
        logic [2:0]  size;
        logic [1:0]  src;
        logic        den;
        logic [31:0] data;
    } exp_t;

    exp_t                exp_q[$];
    logic [31:0]         m_reg [CHANNELS];
    bit                  m_proto = 0;
    bit                  m_to = 0;
    bit                  m_ok = 0;
    int                  m_wd = 0;
    bit                  prev_stall = 0;
    logic [61:0]         prev_fields = '0;
    logic [61:0]         cur_fields;
    logic [CHANNELS-1:0] fin;
    logic [CHANNELS-1:0] fl;
    bit                  cur_ready;
    bit                  is_get;
    bit                  is_put;
    bit                  den;
    int                  idx;
    exp_t                e;

    // Compare DUT against the model, then advance the model across the next edge
    always @(negedge clock) begin
        for (int i = 0; i < CHANNELS; i++) begin
            fin[i] = m_reg[i][0];
            fl[i]  = m_reg[i][0] && (m_reg[i][31:1] != 0);
        end
        if (m_ok) begin
            check("finished", 32'(finished), 32'(fin));
            check("failed", 32'(failed), 32'(fl));
            check("all_done", 32'(all_done), 32'(&fin));
            check("timeout", 32'(timeout), 32'(m_to));
            check("proto_err", 32'(proto_err), 32'(m_proto));
            check("a_ready", 32'(a_ready), 32'(exp_q.size() < RSP_DEPTH));
            check("d_valid", 32'(d_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("d_opcode", 32'(d_opcode), 32'(exp_q[0].op));
                check("d_size", 32'(d_size), 32'(exp_q[0].size));
                check("d_source", 32'(d_source), 32'(exp_q[0].src));
                check("d_denied", 32'(d_denied), 32'(exp_q[0].den));
                check("d_data", d_data, exp_q[0].data);
            end else begin
                check("d_data_idle", d_data, 32'h0);
            end
        end
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) m_reg[i] = '0;
            exp_q.delete();
            m_proto = 0; m_to = 0; m_wd = 0; prev_stall = 0; m_ok = 1;
        end else if (m_ok) begin
            cur_ready  = exp_q.size() < RSP_DEPTH;
            cur_fields = {a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data};
            if (prev_stall && (!a_valid || cur_fields != prev_fields)) m_proto = 1;
            prev_stall  = a_valid && !cur_ready;
            prev_fields = cur_fields;
            if (!(&fin) && !m_to) begin
                m_wd++;
                if (m_wd >= TIMEOUT) m_to = 1;
            end
            if (exp_q.size() != 0 && d_ready) void'(exp_q.pop_front());
            if (a_valid && cur_ready) begin
                idx    = int'(a_address) / 4;
                is_get = (a_opcode == 3'd4);
                is_put = (a_opcode == 3'd0) || (a_opcode == 3'd1);
                den    = (idx >= CHANNELS) || (a_size > 2) || !(is_get || is_put);
                e.op   = is_get ? 3'd1 : 3'd0;
                e.size = a_size;
                e.src  = a_source;
                e.den  = den;
                e.data = (is_get && !den) ? m_reg[idx] : 32'h0;
                exp_q.push_back(e);
                if (!(is_get || is_put) || a_param != 0 || (int'(a_address) % (1 << a_size)) != 0)
                    m_proto = 1;
                if (is_put && !den && !m_reg[idx][0]) begin
                    for (int b = 0; b < 4; b++)
                        if (a_mask[b]) m_reg[idx][8*b +: 8] = a_data[8*b +: 8];
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clock); #1;
        if (rnd_on) d_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1; a_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic set_a(input logic [2:0] op, input logic [2:0] prm, input logic [2:0] sz,
                         input logic [1:0] src, input logic [14:0] addr, input logic [3:0] msk,
                         input logic [31:0] dat);
        a_opcode = op; a_param = prm; a_size = sz; a_source = src;
        a_address = addr; a_mask = msk; a_data = dat;
    endtask

    // Present a request (called just after a rising edge) and hold it until it fires
    task automatic send(input logic [2:0] op, input logic [2:0] prm, input logic [2:0] sz,
                        input logic [1:0] src, input logic [14:0] addr, input logic [3:0] msk,
                        input logic [31:0] dat);
        int n;
        set_a(op, prm, sz, src, addr, msk, dat);
        a_valid = 1'b1;
        n = 0;
        @(negedge clock);
        while (!a_ready && n < 64) begin
            step();
            @(negedge clock);
            n++;
        end
        check("a_accept", 32'(a_ready), 32'h1);
        step();
        a_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        @(negedge clock);
        while (!d_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("rsp_arrival", 32'(d_valid), 32'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

    // ---------------- directed and random sequence ----------------
    initial begin
        logic [2:0]  r_op;
        logic [2:0]  r_prm;
        logic [2:0]  r_sz;
        logic [14:0] r_addr;

        // Reset state and watchdog expiry 20 cycles after release
        do_reset();
        @(negedge clock);
        check("rst_a_ready", 32'(a_ready), 32'h1);
        check("rst_d_valid", 32'(d_valid), 32'h0);
        check("rst_d_data", d_data, 32'h0);
        check("rst_finished", 32'(finished), 32'h0);
        check("rst_failed", 32'(failed), 32'h0);
        check("rst_all_done", 32'(all_done), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        check("rst_proto_err", 32'(proto_err), 32'h0);
        repeat (19) @(negedge clock);
        check("wd_cycle19", 32'(timeout), 32'h0);
        @(negedge clock);
        check("wd_cycle20", 32'(timeout), 32'h1);

        // PutFull done=1 on channel 2
        do_reset();
        send(3'd0, 3'd0, 3'd2, 2'd2, 15'h8, 4'hf, 32'h1);
        wait_rsp();
        check("put_opcode", 32'(d_opcode), 32'h0);
        check("put_source", 32'(d_source), 32'h2);
        check("put_denied", 32'(d_denied), 32'h0);
        check("put_finished", 32'(finished), 32'h4);
        check("put_failed", 32'(failed), 32'h0);

        // PutFull code 2 + done, read back, then confirm the lock
        do_reset();
        send(3'd0, 3'd0, 3'd2, 2'd0, 15'h8, 4'hf, 32'h5);
        send(3'd4, 3'd0, 3'd2, 2'd1, 15'h8, 4'hf, 32'h0);
        wait_rsp();
        check("get_opcode", 32'(d_opcode), 32'h1);
        check("get_data", d_data, 32'h5);
        check("get_finished", 32'(finished), 32'h4);
        check("get_failed", 32'(failed), 32'h4);
        step();
        send(3'd0, 3'd0, 3'd2, 2'd0, 15'h8, 4'hf, 32'h0);
        send(3'd4, 3'd0, 3'd2, 2'd3, 15'h8, 4'hf, 32'h0);
        wait_rsp();
        check("locked_data", d_data, 32'h5);

        // Out-of-range Get and unsupported opcode
        step();
        send(3'd4, 3'd0, 3'd2, 2'd1, 15'h10, 4'hf, 32'h0);
        wait_rsp();
        check("oor_opcode", 32'(d_opcode), 32'h1);
        check("oor_denied", 32'(d_denied), 32'h1);
        check("oor_data", d_data, 32'h0);
        check("oor_proto", 32'(proto_err), 32'h0);
        step();
        send(3'd2, 3'd0, 3'd2, 2'd1, 15'h0, 4'hf, 32'h0);
        wait_rsp();
        check("badop_denied", 32'(d_denied), 32'h1);
        check("badop_proto", 32'(proto_err), 32'h1);

        // Backpressure: queue of two stalls the third Get until a dequeue
        do_reset();
        d_ready = 1'b0;
        send(3'd4, 3'd0, 3'd2, 2'd0, 15'h0, 4'hf, 32'h0);
        send(3'd4, 3'd0, 3'd2, 2'd1, 15'h4, 4'hf, 32'h0);
        set_a(3'd4, 3'd0, 3'd2, 2'd2, 15'h8, 4'hf, 32'h0);
        a_valid = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("full_a_ready", 32'(a_ready), 32'h0);
        end
        @(posedge clock); #1;
        d_ready = 1'b1;
        @(negedge clock);
        check("no_comb_path", 32'(a_ready), 32'h0);
        check("order_0", 32'(d_source), 32'h0);
        @(negedge clock);
        check("ready_after_deq", 32'(a_ready), 32'h1);
        check("order_1", 32'(d_source), 32'h1);
        @(posedge clock); #1;
        a_valid = 1'b0;
        @(negedge clock);
        check("order_2", 32'(d_source), 32'h2);
        check("bp_proto", 32'(proto_err), 32'h0);

        // Stalled request whose address changes, then reset with a full queue
        do_reset();
        d_ready = 1'b0;
        send(3'd4, 3'd0, 3'd2, 2'd0, 15'h0, 4'hf, 32'h0);
        send(3'd4, 3'd0, 3'd2, 2'd1, 15'h4, 4'hf, 32'h0);
        set_a(3'd4, 3'd0, 3'd2, 2'd2, 15'hc, 4'hf, 32'h0);
        a_valid = 1'b1;
        @(negedge clock);
        check("stall_a_ready", 32'(a_ready), 32'h0);
        @(posedge clock); #1;
        a_address = 15'h0;
        @(negedge clock);
        check("proto_before", 32'(proto_err), 32'h0);
        @(negedge clock);
        check("proto_set", 32'(proto_err), 32'h1);
        @(posedge clock); #1;
        a_valid = 1'b0;
        repeat (5) @(negedge clock);
        check("proto_sticky", 32'(proto_err), 32'h1);
        do_reset();
        @(negedge clock);
        check("midrst_d_valid", 32'(d_valid), 32'h0);
        check("midrst_a_ready", 32'(a_ready), 32'h1);
        check("midrst_proto", 32'(proto_err), 32'h0);
        d_ready = 1'b1;

        // All channels done around cycle 10 keeps the watchdog quiet
        do_reset();
        repeat (9) step();
        send(3'd0, 3'd0, 3'd2, 2'd0, 15'h0, 4'hf, 32'h1);
        send(3'd0, 3'd0, 3'd2, 2'd1, 15'h4, 4'hf, 32'h1);
        send(3'd0, 3'd0, 3'd2, 2'd2, 15'h8, 4'hf, 32'h3);
        send(3'd0, 3'd0, 3'd2, 2'd3, 15'hc, 4'hf, 32'h1);
        repeat (30) @(negedge clock);
        check("alldone_flag", 32'(all_done), 32'h1);
        check("alldone_timeout", 32'(timeout), 32'h0);
        check("alldone_failed", 32'(failed), 32'h4);

        // Randomized traffic with random backpressure and occasional resets
        do_reset();
        rnd_on = 1'b1;
        for (int t = 0; t < 240; t++) begin
            if (t % 80 == 79) do_reset();
            repeat ($urandom_range(0, 2)) step();
            case ($urandom_range(0, 9))
                0, 1, 2, 3: r_op = 3'd0;
                4, 5:       r_op = 3'd1;
                6, 7, 8:    r_op = 3'd4;
                default:    r_op = 3'($urandom_range(2, 7));
            endcase
            r_prm  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            r_sz   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            r_addr = 15'($urandom_range(0, 5) * 4);
            if ($urandom_range(0, 9) == 0) r_addr = r_addr ^ 15'($urandom_range(0, 32767));
            send(r_op, r_prm, r_sz, 2'($urandom), r_addr, 4'($urandom), $urandom);
        end
        rnd_on = 1'b0;
        d_ready = 1'b1;
        repeat (6) @(negedge clock);
        check("drain_d_valid", 32'(d_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
